// File: rtl/simple_cpu.sv
// simple_cpu: multicycle 8-bit teaching CPU.
//   One 20-bit instruction per three clocks (FETCH -> DECODE -> EXECUTE).
//   4-entry register file, 32x8 data memory, ADD/SUB ALU.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instruction  instruction word, sampled on the FETCH edge
// Instruction: [19:18] type (00 NOP, 01 ALU, 10 LOAD_R, 11 STORE_R),
//   [17:16] X1, [15:14] X2, [13:12] X3, [11:4] offset, [3:0] ALU op.
// Optional build macro SIMPLE_CPU_TRACE_EN: prints one trace line per
//   EXECUTE edge (time, ir, mnemonic, destination, written value).
module simple_cpu #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);

  localparam int MEM_WORDS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  regfile  [0:3];
  logic [DATA_WIDTH-1:0]  data_mem [0:MEM_WORDS-1];
  logic [DATA_WIDTH-1:0]  opa, opb, data;

  // decoded fields of the held instruction
  logic [1:0] itype, x1, x2, x3;
  logic [7:0] offset;
  logic [3:0] op;
  assign itype  = ir[19:18];
  assign x1     = ir[17:16];
  assign x2     = ir[15:14];
  assign x3     = ir[13:12];
  assign offset = ir[11:4];
  assign op     = ir[3:0];

  // effective address: full-width sum, then truncated so it wraps in memory
  logic [DATA_WIDTH-1:0] addr_sum;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] rdata;
  assign addr_sum = opa + DATA_WIDTH'(offset);
  assign addr     = addr_sum[ADDR_BITS-1:0];
  assign rdata    = data_mem[addr];  // asynchronous read

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_wr;
  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    case (op)
      4'd0: begin alu_res = opa + opb; alu_wr = 1'b1; end
      4'd1: begin alu_res = opa - opb; alu_wr = 1'b1; end
      default: ;  // remaining opcodes are no-ops
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      ir       <= '0;
      regfile  <= '{DATA_WIDTH'(0), DATA_WIDTH'(1), DATA_WIDTH'(2), DATA_WIDTH'(3)};
      data_mem <= '{default: '0};
      opa      <= '0;
      opb      <= '0;
      data     <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: begin
          // operands latched here so X1 aliasing X2/X3 reads the old value
          opa   <= regfile[x2];
          opb   <= regfile[x3];
          data  <= regfile[x1];
          state <= EXECUTE;
        end
        EXECUTE: begin
          case (itype)
            2'b01: if (alu_wr) regfile[x1] <= alu_res;
            2'b10: regfile[x1] <= rdata;
            2'b11: data_mem[addr] <= data;
            default: ;
          endcase
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef SIMPLE_CPU_TRACE_EN
  always @(posedge clk) begin
    if (!rst && state == EXECUTE) begin
      case (itype)
        2'b01: begin
          if (alu_wr)
            $display("%0t ir=%05h %s r%0d <= %0d", $time, ir,
                     (op == 4'd0) ? "ADD" : "SUB", x1, alu_res);
          else
            $display("%0t ir=%05h ALU_NOP op=%0d", $time, ir, op);
        end
        2'b10: $display("%0t ir=%05h LOAD_R r%0d <= %0d", $time, ir, x1, rdata);
        2'b11: $display("%0t ir=%05h STORE_R mem[%0d] <= %0d", $time, ir, addr, data);
        default: $display("%0t ir=%05h NOP", $time, ir);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_simple_cpu.sv
module tb_simple_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] instruction = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_reg [0:3];
  int m_mem [0:31];

  simple_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] enc(input int t, input int a, input int b,
                                      input int c, input int off, input int op);
    logic [19:0] w;
    w = {t[1:0], a[1:0], b[1:0], c[1:0], off[7:0], op[3:0]};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = i;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
  endtask

  // Architectural effect of one instruction, from the ISA rules.
  task automatic model_exec(input logic [19:0] w);
    int t, a, b, c, off, op, addr;
    t = w[19:18]; a = w[17:16]; b = w[15:14]; c = w[13:12];
    off = w[11:4]; op = w[3:0];
    addr = (m_reg[b] + off) % 32;
    case (t)
      1: if (op == 0) m_reg[a] = (m_reg[b] + m_reg[c]) % 256;
         else if (op == 1) m_reg[a] = (m_reg[b] - m_reg[c] + 256) % 256;
      2: m_reg[a] = m_mem[addr];
      3: m_mem[addr] = m_reg[a];
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Presents w for a full instruction period starting at a FETCH edge.
  task automatic run_instr(input logic [19:0] w);
    instruction = w;
    repeat (3) @(posedge clk);
    #1;
    model_exec(w);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut.regfile[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL reset_reg%0d got %0d want %0d", i, dut.regfile[i], i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (dut.data_mem[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_mem%0d got %0d want 0", i, dut.data_mem[i]);
      end
    end
    n_cmp++;
    if (dut.state !== 2'd0 || dut.ir !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_state state=%0d ir=%05h want 0/0", dut.state, dut.ir);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    run_instr(20'b01000111000000000000);
    n_cmp++;
    if (dut.regfile[0] !== 8'd4) begin
      n_bad++; $display("FAIL add1 got %0d want 4", dut.regfile[0]);
    end
    run_instr(20'b01010011000000000000);
    n_cmp++;
    if (dut.regfile[1] !== 8'd7) begin
      n_bad++; $display("FAIL add2 got %0d want 7", dut.regfile[1]);
    end
    run_instr(20'b01110010000000000001);
    n_cmp++;
    if (dut.regfile[3] !== 8'd2) begin
      n_bad++; $display("FAIL sub got %0d want 2", dut.regfile[3]);
    end
    run_instr(20'b11011000000011110000);
    n_cmp++;
    if (dut.data_mem[17] !== 8'd7) begin
      n_bad++; $display("FAIL store17 got %0d want 7", dut.data_mem[17]);
    end
    run_instr(20'b11001100000101100000);
    n_cmp++;
    if (dut.data_mem[24] !== 8'd4) begin
      n_bad++; $display("FAIL store24 got %0d want 4", dut.data_mem[24]);
    end
    run_instr(20'b10111000000011110000);
    n_cmp++;
    if (dut.regfile[3] !== 8'd7) begin
      n_bad++; $display("FAIL load got %0d want 7", dut.regfile[3]);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    run_instr(enc(1, 2, 0, 3, 0, 1));  // r2 = 0 - 3
    n_cmp++;
    if (dut.regfile[2] !== 8'd253) begin
      n_bad++; $display("FAIL sub_wrap got %0d want 253", dut.regfile[2]);
    end
    run_instr(enc(1, 3, 3, 3, 0, 0));  // r3 = 6
    run_instr(enc(1, 3, 3, 1, 0, 0));  // r3 = 7
    run_instr(enc(3, 3, 3, 0, 30, 0)); // mem[(7+30)%32] = 7
    n_cmp++;
    if (dut.data_mem[5] !== 8'd7) begin
      n_bad++; $display("FAIL store_wrap got %0d want 7", dut.data_mem[5]);
    end
    // unimplemented ALU opcode leaves the destination alone
    run_instr(enc(1, 0, 3, 3, 0, 9));
    n_cmp++;
    if (dut.regfile[0] !== 8'd0) begin
      n_bad++; $display("FAIL alu_op9 got %0d want 0", dut.regfile[0]);
    end
  endtask

  task automatic test_reset_mid_instr();
    do_reset();
    run_instr(enc(1, 0, 3, 3, 0, 0));  // r0 = 6
    instruction = enc(1, 1, 3, 3, 0, 0);
    @(posedge clk);                    // FETCH edge
    #1 rst = 1'b1;
    @(posedge clk);                    // would have been DECODE
    #1 rst = 1'b0;
    instruction = '0;
    model_reset();
    n_cmp++;
    if (dut.state !== 2'd0) begin
      n_bad++; $display("FAIL midrst_state got %0d want 0", dut.state);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut.regfile[i] !== 8'(i)) begin
        n_bad++; $display("FAIL midrst_reg%0d got %0d want %0d", i, dut.regfile[i], i);
      end
    end
    // let the aborted slot's EXECUTE edge pass; still nothing may be written
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut.regfile[1] !== 8'd1 || dut.regfile[0] !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_nowb r0=%0d r1=%0d want 0/1", dut.regfile[0], dut.regfile[1]);
    end
    // resync to a FETCH boundary: one more edge completes the NOP slot
    @(posedge clk);
    #1;
  endtask

  // instruction changed after the FETCH edge must be ignored
  task automatic test_hold_ignored();
    logic [19:0] w;
    do_reset();
    w = enc(1, 2, 3, 3, 0, 0);  // r2 = 6
    instruction = w;
    @(posedge clk);
    #1 instruction = enc(1, 2, 1, 1, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    model_exec(w);
    n_cmp++;
    if (dut.regfile[2] !== 8'(m_reg[2])) begin
      n_bad++; $display("FAIL hold got %0d want %0d", dut.regfile[2], m_reg[2]);
    end
  endtask

  task automatic test_random();
    logic [19:0] w;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      w = enc($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255),
              ($urandom_range(0, 7) == 0) ? $urandom_range(2, 15) : $urandom_range(0, 1));
      run_instr(w);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut.regfile[i] !== 8'(m_reg[i])) begin
          n_bad++;
          $display("FAIL rand%0d_reg%0d ir=%05h got %0d want %0d", n, i, w, dut.regfile[i], m_reg[i]);
        end
      end
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut.data_mem[i] !== 8'(m_mem[i])) begin
          n_bad++;
          $display("FAIL rand%0d_mem%0d ir=%05h got %0d want %0d", n, i, w, dut.data_mem[i], m_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_boundaries();
    test_reset_mid_instr();
    test_hold_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
